// File: rtl/vend_dispenser.sv
// Vend output sequencer: one order -> item, then 10-coin, then 5-coin pulses, each held until act_ack.
// First pulse/done one cycle after accept; req_ready only in IDLE (no queueing); missing ack latches fault.
module vend_dispenser #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_items,
  input  logic [3:0] req_change,
  output logic       item_pulse,
  output logic       coin10_pulse,
  output logic       coin5_pulse,
  input  logic       act_ack,
  output logic       busy,
  output logic       done,
  output logic [2:0] resid,
  output logic       fault
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ITEM, ITEM_GAP, C10, C10_GAP, C5, C5_GAP, DONE, FAULT
  } state_t;

  state_t        state, state_n;
  logic [2:0]    n_items, n_items_n;
  logic          n10, n10_n, n5, n5_n;
  logic [2:0]    resid_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [3:0]    rem;
  logic          timeout_hit, gap_end;
  logic          req_ready_n, item_n, c10_n, c5_n, busy_n, done_n, fault_n;

  // Stage priority: items, then tens, then fives; nothing left means the order is done.
  function automatic state_t first_stage(logic [2:0] items, logic tens, logic fives);
    state_t s;
    if (items != 3'd0)  s = ITEM;
    else if (tens)      s = C10;
    else if (fives)     s = C5;
    else                s = DONE;
    return s;
  endfunction

  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  assign gap_end     = (gcnt == GW'(GAP_CYCLES - 1));

  always_comb begin
    state_n   = state;
    n_items_n = n_items;
    n10_n     = n10;
    n5_n      = n5;
    resid_n   = resid;
    tcnt_n    = tcnt;
    gcnt_n    = gcnt;
    rem       = (req_change >= 4'd10) ? req_change - 4'd10 : req_change;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          n_items_n = req_items;
          n10_n     = (req_change >= 4'd10);
          n5_n      = (rem >= 4'd5);
          resid_n   = 3'((rem >= 4'd5) ? rem - 4'd5 : rem);
          state_n   = first_stage(req_items, n10_n, n5_n);
        end
      end
      // Ack beats timeout when both land on the same edge.
      ITEM: begin
        tcnt_n = tcnt + 1'b1;
        if (act_ack) begin
          n_items_n = n_items - 3'd1;
          tcnt_n    = '0;
          state_n   = ITEM_GAP;
        end else if (timeout_hit) begin
          state_n = FAULT;
        end
      end
      C10: begin
        tcnt_n = tcnt + 1'b1;
        if (act_ack) begin
          n10_n   = 1'b0;
          tcnt_n  = '0;
          state_n = C10_GAP;
        end else if (timeout_hit) begin
          state_n = FAULT;
        end
      end
      C5: begin
        tcnt_n = tcnt + 1'b1;
        if (act_ack) begin
          n5_n    = 1'b0;
          tcnt_n  = '0;
          state_n = C5_GAP;
        end else if (timeout_hit) begin
          state_n = FAULT;
        end
      end
      ITEM_GAP, C10_GAP, C5_GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gap_end) begin
          gcnt_n = '0;
          case (state)
            ITEM_GAP: state_n = first_stage(n_items, n10, n5);
            C10_GAP:  state_n = first_stage(3'd0, n10, n5);
            default:  state_n = first_stage(3'd0, 1'b0, n5);
          endcase
        end
      end
      DONE:    state_n = IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase

    req_ready_n = (state_n == IDLE);
    item_n      = (state_n == ITEM);
    c10_n       = (state_n == C10);
    c5_n        = (state_n == C5);
    busy_n      = !((state_n == IDLE) || (state_n == DONE) || (state_n == FAULT));
    done_n      = (state_n == DONE);
    fault_n     = (state_n == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      n_items      <= '0;
      n10          <= 1'b0;
      n5           <= 1'b0;
      resid        <= '0;
      tcnt         <= '0;
      gcnt         <= '0;
      req_ready    <= 1'b1;
      item_pulse   <= 1'b0;
      coin10_pulse <= 1'b0;
      coin5_pulse  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      n_items      <= n_items_n;
      n10          <= n10_n;
      n5           <= n5_n;
      resid        <= resid_n;
      tcnt         <= tcnt_n;
      gcnt         <= gcnt_n;
      req_ready    <= req_ready_n;
      item_pulse   <= item_n;
      coin10_pulse <= c10_n;
      coin5_pulse  <= c5_n;
      busy         <= busy_n;
      done         <= done_n;
      fault        <= fault_n;
    end
  end
endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed and random orders compared against a trace model
// built from the payout rules (items, tens, fives, residue) with random ack delays.
module tb_vend_dispenser;
  localparam int GAP = 2;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_items = '0;
  logic [3:0] req_change = '0;
  logic       act_ack = 1'b0;
  logic       req_ready, item_pulse, coin10_pulse, coin5_pulse, busy, done, fault;
  logic [2:0] resid;

  int    checks = 0;
  int    failures = 0;
  int    want_width[$];
  string obs_trace;
  int    obs_done_t, obs_resid_done, obs_resid_after, busy_err;
  bit    obs_multi, obs_timeout, obs_done_after, obs_ready_after, obs_fault;

  vend_dispenser #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_items(req_items), .req_change(req_change),
    .item_pulse(item_pulse), .coin10_pulse(coin10_pulse), .coin5_pulse(coin5_pulse),
    .act_ack(act_ack), .busy(busy), .done(done), .resid(resid), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; act_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  function automatic int n_pulses(int items, int change);
    return items + change / 10 + (change % 10) / 5;
  endfunction

  task automatic plan(input int p, input int w);
    want_width.delete();
    for (int k = 0; k < p; k++) want_width.push_back((w > 0) ? w : int'($urandom_range(1, TMO)));
  endtask

  // Expected trace: per pulse "<kind><width>:<gap> ", then "D".
  function automatic string model_trace(int items, int change);
    string s = "";
    string c;
    for (int i = 0; i < n_pulses(items, change); i++) begin
      if (i < items) c = "I";
      else if (i < items + change / 10) c = "T";
      else c = "F";
      s = {s, $sformatf("%s%0d:%0d ", c, want_width[i], GAP)};
    end
    return {s, "D"};
  endfunction

  function automatic int model_done_t(int p);
    int t = 1 + p * GAP;
    foreach (want_width[k]) t += want_width[k];
    return t;
  endfunction

  // Drives one order and records what the actuators saw; garbage req_valid is applied while busy.
  task automatic run_order(input int items, input int change, input bit stray);
    int    t = 1, run = 0, idle = 0, pidx = 0, wcur = 1;
    string cur = "", now;
    obs_trace = ""; obs_done_t = -1; obs_multi = 0; busy_err = 0;
    req_valid = 1'b1; req_items = 3'(items); req_change = 4'(change);
    step();
    while (obs_done_t < 0 && t < 300) begin
      act_ack = 1'b0;
      req_valid = 1'($urandom_range(0, 1)); req_items = 3'($urandom); req_change = 4'($urandom);
      if (int'(item_pulse) + int'(coin10_pulse) + int'(coin5_pulse) > 1) obs_multi = 1;
      if (item_pulse || coin10_pulse || coin5_pulse) begin
        if (item_pulse) now = "I"; else if (coin10_pulse) now = "T"; else now = "F";
        if (!busy) busy_err++;
        if (run > 0 && now != cur) begin
          obs_trace = {obs_trace, $sformatf("%s%0d:", cur, run)};
          run = 0;
        end
        if (run == 0) begin
          if (pidx > 0) obs_trace = {obs_trace, $sformatf("%0d ", idle)};
          cur  = now;
          wcur = (pidx < want_width.size()) ? want_width[pidx] : 1;
          pidx++;
        end
        run++; idle = 0;
        if (run >= wcur) act_ack = 1'b1;
      end else begin
        if (run > 0) begin
          obs_trace = {obs_trace, $sformatf("%s%0d:", cur, run)};
          run = 0;
        end
        if (done) begin
          if (pidx > 0) obs_trace = {obs_trace, $sformatf("%0d ", idle)};
          obs_trace = {obs_trace, "D"};
          obs_done_t = t;
          obs_resid_done = int'(resid);
          if (busy) busy_err++;
        end else begin
          if (!busy) busy_err++;
          idle++;
          if (stray && idle == 1) act_ack = 1'b1;
        end
      end
      step(); t++;
    end
    act_ack = 1'b0; req_valid = 1'b0;
    obs_timeout     = (obs_done_t < 0);
    obs_done_after  = done;
    obs_ready_after = req_ready;
    obs_resid_after = int'(resid);
    obs_fault       = fault;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    checks++; if ({item_pulse, coin10_pulse, coin5_pulse} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses got=%b%b%b want=000", item_pulse, coin10_pulse, coin5_pulse); end
    checks++; if ({busy, done, fault} !== 3'b000) begin failures++;
      $display("FAIL reset_status busy/done/fault got=%b%b%b want=000", busy, done, fault); end
    checks++; if (resid !== 3'd0) begin failures++; $display("FAIL reset_resid got=%0d want=0", resid); end
  endtask

  task automatic test_directed();
    int   t_items[7]  = '{2, 1, 0, 0, 1, 1, 7};
    int   t_change[7] = '{10, 14, 3, 0, 5, 0, 15};
    int   t_w[7]      = '{1, 1, 1, 1, 5, TMO, 1};
    bit   t_stray[7]  = '{0, 0, 0, 0, 1, 0, 1};
    int   p, exp_t;
    string exp_trace;
    for (int i = 0; i < 7; i++) begin
      p = n_pulses(t_items[i], t_change[i]);
      plan(p, t_w[i]);
      exp_trace = model_trace(t_items[i], t_change[i]);
      exp_t = model_done_t(p);
      run_order(t_items[i], t_change[i], t_stray[i]);
      checks++; if (obs_trace != exp_trace) begin failures++;
        $display("FAIL dir%0d_trace got=\"%s\" want=\"%s\"", i, obs_trace, exp_trace); end
      checks++; if (obs_timeout || obs_done_t != exp_t) begin failures++;
        $display("FAIL dir%0d_done_cycle got=%0d want=%0d", i, obs_done_t, exp_t); end
      checks++; if (obs_resid_done != t_change[i] % 5 || obs_resid_after != t_change[i] % 5) begin failures++;
        $display("FAIL dir%0d_resid got=%0d/%0d want=%0d", i, obs_resid_done, obs_resid_after, t_change[i] % 5); end
      checks++; if (obs_multi || busy_err != 0) begin failures++;
        $display("FAIL dir%0d_onehot_busy multi=%0d busy_err=%0d want=0/0", i, obs_multi, busy_err); end
      checks++; if (obs_done_after !== 1'b0 || obs_ready_after !== 1'b1 || obs_fault !== 1'b0) begin failures++;
        $display("FAIL dir%0d_after done/ready/fault got=%b%b%b want=010", i, obs_done_after, obs_ready_after, obs_fault); end
    end
  endtask

  task automatic test_back_to_back();
    int items, change, p, exp_t;
    string exp_trace;
    for (int i = 0; i < 25; i++) begin
      items  = int'($urandom_range(0, 7));
      change = int'($urandom_range(0, 15));
      p = n_pulses(items, change);
      plan(p, 0);
      exp_trace = model_trace(items, change);
      exp_t = model_done_t(p);
      run_order(items, change, 1'($urandom_range(0, 1)));
      checks++; if (obs_trace != exp_trace) begin failures++;
        $display("FAIL rnd%0d_trace items=%0d change=%0d got=\"%s\" want=\"%s\"", i, items, change, obs_trace, exp_trace); end
      checks++; if (obs_timeout || obs_done_t != exp_t) begin failures++;
        $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", i, obs_done_t, exp_t); end
      checks++; if (obs_resid_done != change % 5 || obs_resid_after != change % 5) begin failures++;
        $display("FAIL rnd%0d_resid got=%0d/%0d want=%0d", i, obs_resid_done, obs_resid_after, change % 5); end
      checks++; if (obs_multi || busy_err != 0 || obs_done_after !== 1'b0 || obs_ready_after !== 1'b1 || obs_fault !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_status multi=%0d busy_err=%0d done/ready/fault=%b%b%b want 0 0 010",
                 i, obs_multi, busy_err, obs_done_after, obs_ready_after, obs_fault); end
    end
  endtask

  task automatic test_timeout();
    int hi = 0, seen = 0;
    do_reset();
    req_valid = 1'b1; req_items = 3'd1; req_change = 4'd0;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 40 && !fault; c++) begin
      if (item_pulse) hi++;
      step();
    end
    checks++; if (hi != TMO) begin failures++; $display("FAIL timeout_width got=%0d want=%0d", hi, TMO); end
    checks++; if (fault !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL timeout_status fault/ready/busy got=%b%b%b want=100", fault, req_ready, busy); end
    checks++; if ({item_pulse, coin10_pulse, coin5_pulse} !== 3'b000) begin failures++;
      $display("FAIL timeout_pulses got=%b%b%b want=000", item_pulse, coin10_pulse, coin5_pulse); end
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_items = 3'd3; req_change = 4'd15; act_ack = 1'($urandom_range(0, 1));
      step();
      if (item_pulse || coin10_pulse || coin5_pulse || req_ready || !fault || done) seen++;
    end
    req_valid = 1'b0; act_ack = 1'b0;
    checks++; if (seen != 0) begin failures++; $display("FAIL fault_sticky bad_cycles got=%0d want=0", seen); end
    do_reset();
    checks++; if (req_ready !== 1'b1 || fault !== 1'b0) begin failures++;
      $display("FAIL fault_clear ready/fault got=%b%b want=10", req_ready, fault); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    string exp_trace;
    req_valid = 1'b1; req_items = 3'd0; req_change = 4'd14;
    step();
    req_valid = 1'b0;
    while (!coin10_pulse && c < 10) begin step(); c++; end
    checks++; if (coin10_pulse !== 1'b1) begin failures++; $display("FAIL midreset_reach coin10 got=%b want=1", coin10_pulse); end
    reset = 1'b1;
    step();
    checks++; if (coin10_pulse !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || resid !== 3'd0) begin failures++;
      $display("FAIL midreset_state coin10=%b ready=%b busy=%b resid=%0d want 0 1 0 0", coin10_pulse, req_ready, busy, resid); end
    reset = 1'b0;
    plan(n_pulses(1, 14), 1);
    exp_trace = model_trace(1, 14);
    run_order(1, 14, 1'b0);
    checks++; if (obs_trace != exp_trace || obs_resid_done != 4) begin failures++;
      $display("FAIL midreset_next got=\"%s\" resid=%0d want=\"%s\" resid=4", obs_trace, obs_resid_done, exp_trace); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
